// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, field offsets, excodes, bus layouts.
// No logic; types and constants only.
// No flow control of its own; consumed by mem_stage and its sub-module.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 125;
  localparam int MS_TO_WS_BUS_WD = 85;

  // Field offsets (LSB position) inside es_to_ms_bus
  localparam int ES_ERET_OFS     = 124;
  localparam int ES_BD_OFS       = 123;
  localparam int ES_MTC0_WE_OFS  = 122;
  localparam int ES_CP0_ADDR_OFS = 117;
  localparam int ES_EX_OFS       = 116;
  localparam int ES_EXCODE_OFS   = 111;
  localparam int ES_RES_CP0_OFS  = 110;
  localparam int ES_LWL_OFS      = 109;
  localparam int ES_LWR_OFS      = 108;
  localparam int ES_RT_OFS       = 76;
  localparam int ES_LW_OFS       = 75;
  localparam int ES_LH_OFS       = 74;
  localparam int ES_LB_OFS       = 73;
  localparam int ES_SIGN_OFS     = 72;
  localparam int ES_A10_OFS      = 70;
  localparam int ES_GR_WE_OFS    = 69;
  localparam int ES_DEST_OFS     = 64;
  localparam int ES_ALU_OFS      = 32;
  localparam int ES_PC_OFS       = 0;

  // Field offsets (LSB position) inside ms_to_ws_bus
  localparam int MS_ERET_OFS     = 84;
  localparam int MS_EX_OFS       = 76;
  localparam int MS_GR_WE_OFS    = 69;
  localparam int MS_FINAL_OFS    = 32;
  localparam int MS_PC_OFS       = 0;

  // Exception codes
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef struct packed {
    logic        eret;
    logic        bd;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic        ex;
    logic [4:0]  excode;
    logic        res_from_cp0;
    logic        lwl;
    logic        lwr;
    logic [31:0] rt_value;
    logic        lw;
    logic        lh;
    logic        lb;
    logic        sign;
    logic [1:0]  a10;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        eret;
    logic        bd;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic        ex;
    logic [4:0]  excode;
    logic        res_from_cp0;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  // True when the instruction reads its result from data memory
  function automatic logic is_load(input es_to_ms_t b);
    return b.lw | b.lh | b.lb | b.lwl | b.lwr;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Aligns/extends SRAM read data for lw/lh/lb/lwl/lwr, merging rt for partial-word loads.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module mem_load_align (
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  input  logic [1:0]  a10,
  input  logic        lw,
  input  logic        lh,
  input  logic        lb,
  input  logic        lwl,
  input  logic        lwr,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    byte_sel = rdata[7:0];
    case (a10)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = a10[1] ? rdata[31:16] : rdata[15:0];
  end

  // Form the register write value; unaligned loads keep the untouched rt bytes
  always_comb begin
    data = 32'h0;
    if (lwl) begin
      case (a10)
        2'd0: data = {rdata[7:0],  rt[23:0]};
        2'd1: data = {rdata[15:0], rt[15:0]};
        2'd2: data = {rdata[23:0], rt[7:0]};
        default: data = rdata;
      endcase
    end else if (lwr) begin
      case (a10)
        2'd0: data = rdata;
        2'd1: data = {rt[31:24], rdata[31:8]};
        2'd2: data = {rt[31:16], rdata[31:16]};
        default: data = {rt[31:8], rdata[31:24]};
      endcase
    end else if (lh) begin
      data = {{16{sign & half_sel[15]}}, half_sel};
    end else if (lb) begin
      data = {{24{sign & byte_sel[7]}}, byte_sel};
    end else if (lw) begin
      data = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EXE payload, aligns load data, builds the WB payload.
// One register stage; the result leaves in the cycle after acceptance when WB is ready.
// Holds while WB stalls, latching the one-shot SRAM read data so it survives the stall.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [9:0]                 es_to_ms_addr,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ex_from_ws,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [9:0]                 ms_to_ws_addr,
  output logic                       ex_from_ms,
  output logic [31:0]                es_forward_ms,
  output logic                       ms_valid_h,
  output logic                       ms_res_from_mem_h,
  output logic                       ms_res_from_cp0_h
);

  logic        ms_valid;
  es_to_ms_t   bus_r;
  logic [9:0]  addr_r;
  logic [31:0] hold_rdata;
  logic        held;
  logic        leaving;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] final_result;
  ms_to_ws_t   ws_bus;

  // The stage never needs extra cycles, so ready_go is tied high
  assign ms_allowin     = !ms_valid || ws_allowin;
  assign ms_to_ws_valid = ms_valid;
  assign leaving        = ms_valid && ws_allowin;

  // Valid bit: flush from WB wins over new acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ex_from_ws) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Payload registers load even during a flush; valid is cleared so the data is inert
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_r  <= '0;
      addr_r <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      bus_r  <= es_to_ms_bus;
      addr_r <= es_to_ms_addr;
    end
  end

  // SRAM data is only valid in the first MEM cycle; capture it when that cycle stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_rdata <= '0;
      held       <= 1'b0;
    end else if (ex_from_ws || leaving) begin
      held <= 1'b0;
    end else if (ms_valid && !held) begin
      hold_rdata <= data_sram_rdata;
      held       <= 1'b1;
    end
  end

  assign rdata_eff = held ? hold_rdata : data_sram_rdata;

  mem_load_align u_load_align (
    .rdata (rdata_eff),
    .rt    (bus_r.rt_value),
    .a10   (bus_r.a10),
    .lw    (bus_r.lw),
    .lh    (bus_r.lh),
    .lb    (bus_r.lb),
    .lwl   (bus_r.lwl),
    .lwr   (bus_r.lwr),
    .sign  (bus_r.sign),
    .data  (load_data)
  );

  // On an exception alu_result carries BadVAddr, so it overrides load data
  assign final_result = bus_r.ex         ? bus_r.alu_result :
                        is_load(bus_r)   ? load_data        :
                                           bus_r.alu_result;

  assign ws_bus.eret         = bus_r.eret;
  assign ws_bus.bd           = bus_r.bd;
  assign ws_bus.mtc0_we      = bus_r.mtc0_we;
  assign ws_bus.cp0_addr     = bus_r.cp0_addr;
  assign ws_bus.ex           = bus_r.ex;
  assign ws_bus.excode       = bus_r.excode;
  assign ws_bus.res_from_cp0 = bus_r.res_from_cp0;
  assign ws_bus.gr_we        = bus_r.gr_we && !bus_r.ex;
  assign ws_bus.dest         = bus_r.dest;
  assign ws_bus.final_result = final_result;
  assign ws_bus.pc           = bus_r.pc;

  assign ms_to_ws_bus  = ws_bus;
  assign ms_to_ws_addr = addr_r;

  // EXE uses this to squash stores and the divider behind a trapping instruction
  assign ex_from_ms = ms_valid && (bus_r.ex || bus_r.eret || bus_r.mtc0_we) && !ex_from_ws;

  assign es_forward_ms     = final_result;
  assign ms_valid_h        = ms_valid;
  assign ms_res_from_mem_h = ms_valid && is_load(bus_r);
  assign ms_res_from_cp0_h = ms_valid && bus_r.res_from_cp0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/exception/reset cases plus random traffic.
// Drives inputs at the falling edge and samples outputs 1 ns later.
// Random traffic uses random WB backpressure against a queue-free behavioural model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [124:0] es_to_ms_bus;
  logic [9:0]   es_to_ms_addr;
  logic [31:0]  data_sram_rdata;
  logic         ex_from_ws;
  logic         ms_to_ws_valid;
  logic [84:0]  ms_to_ws_bus;
  logic [9:0]   ms_to_ws_addr;
  logic         ex_from_ms;
  logic [31:0]  es_forward_ms;
  logic         ms_valid_h;
  logic         ms_res_from_mem_h;
  logic         ms_res_from_cp0_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_to_ms_addr     (es_to_ms_addr),
    .data_sram_rdata   (data_sram_rdata),
    .ex_from_ws        (ex_from_ws),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ws_addr     (ms_to_ws_addr),
    .ex_from_ms        (ex_from_ms),
    .es_forward_ms     (es_forward_ms),
    .ms_valid_h        (ms_valid_h),
    .ms_res_from_mem_h (ms_res_from_mem_h),
    .ms_res_from_cp0_h (ms_res_from_cp0_h)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [124:0] b, input logic [31:0] rd);
    logic [31:0] rt, v;
    int sh;
    rt = b[107:76];
    sh = 8 * int'(b[71:70]);
    v  = b[63:32];
    if (b[116])      v = b[63:32];
    else if (b[109]) v = (rd << (24 - sh)) | (rt & ((32'h1 << (24 - sh)) - 32'h1));
    else if (b[108]) v = (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
    else if (b[75])  v = rd;
    else if (b[74]) begin
      v = (rd >> (16 * int'(b[71]))) & 32'hFFFF;
      if (b[72] && v[15]) v = v | 32'hFFFF_0000;
    end else if (b[73]) begin
      v = (rd >> sh) & 32'hFF;
      if (b[72] && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [84:0] ref_out(input logic [124:0] b, input logic [31:0] rd);
    return {b[124:110], b[69] & ~b[116], b[68:64], ref_result(b, rd), b[31:0]};
  endfunction

  function automatic logic ref_is_load(input logic [124:0] b);
    return b[109] | b[108] | b[75] | b[74] | b[73];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic ws, input logic esv, input logic [124:0] b,
                       input logic [9:0] a, input logic [31:0] rd, input logic exws);
    @(negedge clk);
    ws_allowin      = ws;
    es_to_ms_valid  = esv;
    es_to_ms_bus    = b;
    es_to_ms_addr   = a;
    data_sram_rdata = rd;
    ex_from_ws      = exws;
    #1;
  endtask

  function automatic logic [124:0] mk_load(input int kind, input logic sign, input logic [1:0] a10,
                                           input logic [31:0] rt, input logic [31:0] alu);
    logic [124:0] b;
    b = '0;
    b[107:76] = rt;
    b[72]     = sign;
    b[71:70]  = a10;
    b[69]     = 1'b1;
    b[68:64]  = 5'd9;
    b[63:32]  = alu;
    b[31:0]   = 32'hBFC0_0100;
    case (kind)
      0: b[75]  = 1'b1;
      1: b[74]  = 1'b1;
      2: b[73]  = 1'b1;
      3: b[109] = 1'b1;
      4: b[108] = 1'b1;
      default: ;
    endcase
    return b;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    es_to_ms_addr = '0; data_sram_rdata = '0; ex_from_ws = 1'b0;
    #2;
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ex_from_ms !== 1'b0 ||
        ms_res_from_mem_h !== 1'b0 || ms_res_from_cp0_h !== 1'b0 || ms_to_ws_bus !== 85'h0) begin
      errors++;
      $display("FAIL reset_during: valid=%b allowin=%b exms=%b mem=%b cp0=%b bus=%h, want 0 1 0 0 0 0",
               ms_to_ws_valid, ms_allowin, ex_from_ms, ms_res_from_mem_h, ms_res_from_cp0_h, ms_to_ws_bus);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, '1, 10'h3ff, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ex_from_ms !== 1'b0 ||
        ms_to_ws_bus !== 85'h0 || ms_to_ws_addr !== 10'h0) begin
      errors++;
      $display("FAIL reset_after: valid=%b allowin=%b exms=%b bus=%h addr=%h, want 0 1 0 0 0",
               ms_to_ws_valid, ms_allowin, ex_from_ms, ms_to_ws_bus, ms_to_ws_addr);
    end
  endtask

  task automatic test_lb_sign;
    drive(1'b1, 1'b1, mk_load(2, 1'b1, 2'd3, 32'h0, 32'h1000_0003), 10'h155, 32'h0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 32'h80FF_1234, 1'b0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hFFFF_FF80 || ms_to_ws_bus[69] !== 1'b1) begin
      errors++;
      $display("FAIL lb_sign: valid=%b result=%h gr_we=%b, want 1 ffffff80 1",
               ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[69]);
    end
    checks++;
    if (ms_res_from_mem_h !== 1'b1 || es_forward_ms !== 32'hFFFF_FF80 || ms_to_ws_addr !== 10'h155) begin
      errors++;
      $display("FAIL lb_side: memh=%b fwd=%h addr=%h, want 1 ffffff80 155",
               ms_res_from_mem_h, es_forward_ms, ms_to_ws_addr);
    end
  endtask

  task automatic test_lwl_lwr;
    drive(1'b1, 1'b1, mk_load(3, 1'b0, 2'd1, 32'h1122_3344, 32'h0), 10'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, mk_load(4, 1'b0, 2'd2, 32'h1122_3344, 32'h0), 10'h0, 32'hAABB_CCDD, 1'b0);
    checks++;
    if (ms_to_ws_bus[63:32] !== 32'hCCDD_3344) begin
      errors++;
      $display("FAIL lwl_a1: got %h want ccdd3344", ms_to_ws_bus[63:32]);
    end
    drive(1'b1, 1'b0, '0, '0, 32'hAABB_CCDD, 1'b0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1122_AABB) begin
      errors++;
      $display("FAIL lwr_a2: valid=%b got %h want 1 1122aabb", ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
  endtask

  task automatic test_stall_hold;
    logic [124:0] lw;
    lw = mk_load(0, 1'b0, 2'd0, 32'h0, 32'h0000_0040);
    drive(1'b1, 1'b1, lw, 10'h021, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, mk_load(0, 1'b0, 2'd0, 32'h0, 32'h44), 10'h3ff,
            (i == 0) ? 32'h1357_9BDF : 32'hDEAD_BEEF, 1'b0);
      checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0 || ms_to_ws_bus[63:32] !== 32'h1357_9BDF ||
          ms_to_ws_addr !== 10'h021) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b allowin=%b result=%h addr=%h, want 1 0 13579bdf 021",
                 i, ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32], ms_to_ws_addr);
      end
    end
    drive(1'b1, 1'b0, '0, '0, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL stall_release: valid=%b allowin=%b result=%h, want 1 1 13579bdf",
               ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]);
    end
    drive(1'b1, 1'b0, '0, '0, 32'h0, 1'b0);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: valid=%b want 0", ms_to_ws_valid);
    end
  endtask

  task automatic test_exception_flush;
    logic [124:0] b;
    b = mk_load(0, 1'b0, 2'd0, 32'h0, 32'h0000_0003);
    b[116] = 1'b1;
    b[115:111] = 5'h04;
    drive(1'b1, 1'b1, b, 10'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 32'h5555_AAAA, 1'b0);
    checks++;
    if (ex_from_ms !== 1'b1 || ms_to_ws_bus[69] !== 1'b0 || ms_to_ws_bus[63:32] !== 32'h3 ||
        ms_to_ws_bus[76] !== 1'b1 || ms_to_ws_bus[75:71] !== 5'h04) begin
      errors++;
      $display("FAIL exc_in_mem: exms=%b gr_we=%b result=%h ex=%b excode=%h, want 1 0 00000003 1 04",
               ex_from_ms, ms_to_ws_bus[69], ms_to_ws_bus[63:32], ms_to_ws_bus[76], ms_to_ws_bus[75:71]);
    end
    drive(1'b1, 1'b1, mk_load(0, 1'b0, 2'd0, 32'h0, 32'h77), 10'h0, 32'h0, 1'b1);
    checks++;
    if (ex_from_ms !== 1'b0) begin
      errors++;
      $display("FAIL exc_flush_mask: exms=%b want 0", ex_from_ms);
    end
    drive(1'b1, 1'b0, '0, '0, 32'h0, 1'b0);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_valid_h !== 1'b0 || ms_res_from_mem_h !== 1'b0) begin
      errors++;
      $display("FAIL exc_flushed: valid=%b valid_h=%b memh=%b, want 0 0 0",
               ms_to_ws_valid, ms_valid_h, ms_res_from_mem_h);
    end
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b1, 1'b1, mk_load(0, 1'b0, 2'd0, 32'h0, 32'h0), 10'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 32'hCAFE_F00D, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 32'hCAFE_F00D, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_to_ws_bus !== 85'h0) begin
      errors++;
      $display("FAIL reset_mid_stall: valid=%b allowin=%b bus=%h, want 0 1 0",
               ms_to_ws_valid, ms_allowin, ms_to_ws_bus);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, mk_load(0, 1'b0, 2'd0, 32'h0, 32'h0), 10'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 32'h0102_0304, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 32'hCAFE_F00D, 1'b0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0102_0304) begin
      errors++;
      $display("FAIL reset_no_stale: valid=%b result=%h, want 1 01020304",
               ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    drive(1'b1, 1'b0, '0, '0, 32'h0, 1'b0);
  endtask

  task automatic test_random;
    logic         occ, first;
    logic [124:0] cur, nb;
    logic [9:0]   cur_a, na;
    logic [31:0]  cur_rd, rd;
    logic         ws, esv, allow;
    occ = 1'b0; first = 1'b0; cur = '0; cur_a = '0; cur_rd = '0;
    for (int n = 0; n < 400; n++) begin
      ws  = ($urandom_range(0, 9) < 7);
      esv = ($urandom_range(0, 3) != 0);
      nb  = {$urandom, $urandom, $urandom, $urandom};
      nb[109] = 1'b0; nb[108] = 1'b0; nb[75] = 1'b0; nb[74] = 1'b0; nb[73] = 1'b0;
      case ($urandom_range(0, 5))
        0: nb[75]  = 1'b1;
        1: nb[74]  = 1'b1;
        2: nb[73]  = 1'b1;
        3: nb[109] = 1'b1;
        4: nb[108] = 1'b1;
        default: ;
      endcase
      nb[116] = ($urandom_range(0, 4) == 0);
      nb[124] = ($urandom_range(0, 7) == 0);
      nb[122] = ($urandom_range(0, 7) == 0);
      na = 10'($urandom);
      rd = (occ && first) ? cur_rd : $urandom;
      drive(ws, esv, nb, na, rd, 1'b0);
      allow = !occ || ws;
      checks++;
      if (ms_to_ws_valid !== occ || ms_allowin !== allow) begin
        errors++;
        $display("FAIL rand_hs[%0d]: valid=%b allowin=%b, want %b %b", n, ms_to_ws_valid, ms_allowin, occ, allow);
      end
      if (occ) begin
        checks++;
        if (ms_to_ws_bus !== ref_out(cur, cur_rd) || ms_to_ws_addr !== cur_a ||
            es_forward_ms !== ref_result(cur, cur_rd)) begin
          errors++;
          $display("FAIL rand_data[%0d]: bus=%h addr=%h fwd=%h, want %h %h %h", n, ms_to_ws_bus,
                   ms_to_ws_addr, es_forward_ms, ref_out(cur, cur_rd), cur_a, ref_result(cur, cur_rd));
        end
        checks++;
        if (ex_from_ms !== (cur[116] | cur[124] | cur[122]) || ms_res_from_mem_h !== ref_is_load(cur) ||
            ms_res_from_cp0_h !== cur[110]) begin
          errors++;
          $display("FAIL rand_side[%0d]: exms=%b memh=%b cp0h=%b", n, ex_from_ms, ms_res_from_mem_h,
                   ms_res_from_cp0_h);
        end
      end
      first = 1'b0;
      if (allow) begin
        occ = esv;
        if (esv) begin
          cur = nb; cur_a = na; cur_rd = $urandom; first = 1'b1;
        end
      end
    end
    drive(1'b1, 1'b0, '0, '0, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_lb_sign;
    test_lwl_lwr;
    test_stall_hold;
    test_exception_flush;
    test_reset_mid_stall;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL use one clock, clk; reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  pipeline clock
- reset  in  1  async active-high reset
- ws_allowin  in  1  WB stage can accept
- ms_allowin  out  1  MEM stage can accept
- es_to_ms_valid  in  1  EXE output valid
- es_to_ms_bus  in  125  EXE payload; field map in REQ-006
- es_to_ms_addr  in  10  {rs,rt} register addresses of the instruction
- data_sram_rdata  in  32  sync SRAM read data, one cycle after the EXE request
- ex_from_ws  in  1  flush from WB
- ms_to_ws_valid  out  1  MEM output valid
- ms_to_ws_bus  out  85  WB payload; field map in REQ-010
- ms_to_ws_addr  out  10  registered es_to_ms_addr
- ex_from_ms  out  1  exception or ERET held in MEM; EXE suppresses stores and the divider
- es_forward_ms  out  32  forwarding value (final result)
- ms_valid_h  out  1  ms_valid, for the hazard unit
- ms_res_from_mem_h  out  1  load in MEM and valid, for load-use stall
- ms_res_from_cp0_h  out  1  MFC0 in MEM and valid

Function
REQ-003 ms_ready_go SHALL be 1.
- ms_allowin = !ms_valid || ws_allowin.
- ms_to_ws_valid = ms_valid.
REQ-004 On each clk edge:
- if ex_from_ws, ms_valid SHALL become 0;
- else if ms_allowin, ms_valid SHALL become es_to_ms_valid.
REQ-005 When es_to_ms_valid && ms_allowin, the bus register and addr register SHALL load. This rule applies even in the same cycle as ex_from_ws, because the loaded data is discarded.
REQ-006 es_to_ms_bus fields, MSB first:
- eret[124], bd[123], mtc0_we[122], cp0_addr[121:117], ex[116], excode[115:111], res_from_cp0[110]
- lwl[109], lwr[108], rt_value[107:76], lw[75], lh[74], lb[73], sign[72]
- a10[71:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]
REQ-007 Load data SHALL be extracted from rdata using a10, as follows.
- lw: rdata.
- lh: half select = a10[1]; sign-extend if sign, else zero-extend.
- lb: byte select = a10; sign-extend if sign, else zero-extend.
- lwl, by a10 = 0/1/2/3:
  - 0: {rdata[7:0], rt[23:0]}
  - 1: {rdata[15:0], rt[15:0]}
  - 2: {rdata[23:0], rt[7:0]}
  - 3: rdata
- lwr, by a10 = 0/1/2/3:
  - 0: rdata
  - 1: {rt[31:24], rdata[31:8]}
  - 2: {rt[31:16], rdata[31:16]}
  - 3: {rt[31:8], rdata[31:24]}
REQ-008 final_result SHALL be:
- alu_result when ex=1; this carries BadVAddr;
- else the load data when any load flag is set;
- else alu_result.
REQ-009 gr_we to WB SHALL be gr_we && !ex.
REQ-010 ms_to_ws_bus fields, MSB first: eret, bd, mtc0_we, cp0_addr[5], ex, excode[5], res_from_cp0, gr_we, dest[5], final_result[32], pc[32]; total 85 bits.
REQ-011 ex_from_ms SHALL equal ms_valid && (ex || eret || mtc0_we) && !ex_from_ws.
REQ-012 es_forward_ms SHALL equal final_result regardless of ms_valid. Gating is done by the hazard unit.
REQ-013 ms_res_from_mem_h SHALL equal ms_valid && (lw|lh|lb|lwl|lwr).
REQ-014 ms_res_from_cp0_h SHALL equal ms_valid && res_from_cp0.
REQ-015 While ms_valid && !ws_allowin, the registers SHALL hold. The rdata sampled in the cycle after acceptance SHALL be captured into a 32-bit hold register on the first stalled cycle, with a one-bit "held" flag. Extraction SHALL use the held data until the instruction leaves. The flag SHALL be cleared when the instruction leaves or on flush.

Reset
REQ-016 On reset the module SHALL clear ms_valid, the held flag, the bus register, the addr register and the hold register.
REQ-017 During and immediately after reset:
- ms_to_ws_valid=0, ms_allowin=1, ex_from_ms=0
- ms_res_from_mem_h=0, ms_res_from_cp0_h=0
- ms_to_ws_bus=0 except pc=0
REQ-018 Reset asserted mid-stall SHALL discard the held data.

Structure
REQ-019 The shared header SHALL hold ES_TO_MS_BUS_WD=125, MS_TO_WS_BUS_WD=85, the field offsets, and the excode constants (AdEL=04, AdES=05, Ov=0C).
REQ-020 Load extraction SHALL be one combinational sub-module, mem_load_align (inputs: rdata, rt, a10, load flags; output: 32-bit data).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- lb sign=1, a10=3, rdata=0x80FF_1234 -> final_result=0xFFFF_FF80, gr_we=1.
- lwl a10=1, rdata=0xAABB_CCDD, rt=0x1122_3344 -> final_result=0xCCDD_3344.
- lwr a10=2, same data -> final_result=0x1122_AABB.
- lw, ws_allowin=0 for 3 cycles, rdata changed to 0xDEAD_BEEF after the first stalled cycle -> output holds the original rdata, ms_to_ws_valid stays 1, and it is accepted on the release cycle.
- ex=1, excode=04, alu_result=0x0000_0003 -> ex_from_ms=1, gr_we=0, final_result=0x3; the next cycle with ex_from_ws=1 -> ms_valid=0 and the new input is ignored.
- reset pulsed mid-stall -> ms_to_ws_valid=0 and ms_allowin=1 in the same cycle; no stale data appears after release.
